inst_fetch: RTL and testbench

- Fetch unit: the requesting end of the instruction-memory read interface.
- Drives the 10-bit instruction address, captures the returned 9-bit instruction into a registered output for decode, and advances the PC.
- Handles redirect on taken branch, stall from decode, and halt detection with Start/Done sequencing for the testbench.

---
 rtl/inst_fetch.sv | 152 +++++++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
//==============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. Drives the instruction-memory address
//               from the PC, registers the returned word for decode, handles
//               branch redirect, decode stall and halt detection with
//               Start/Done sequencing.
//               Optional fetch counter enabled by defining FETCH_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module inst_fetch #(
    parameter logic [9:0] START_ADDR = 10'd0,
    parameter logic [8:0] HALT_WORD  = 9'b111111111
`ifdef FETCH_CNT_EN
    ,
    parameter int         CNT_W      = 16
`endif
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [9:0]  BranchTarget,
    input  logic [8:0]  Instruction,
    output logic [9:0]  Address,
    output logic [8:0]  InstOut,
    output logic        InstValid,
    output logic        Done
`ifdef FETCH_CNT_EN
    ,
    output logic [CNT_W-1:0] InstCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_pc;
    logic [9:0] w_pc_nxt;
    logic [8:0] r_inst;
    logic [8:0] w_inst_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_done;
    logic       w_done_nxt;
`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
`endif

    assign Address   = r_pc;
    assign InstOut   = r_inst;
    assign InstValid = r_valid;
    assign Done      = r_done;
`ifdef FETCH_CNT_EN
    assign InstCount = r_cnt;
`endif

    // State and datapath registers; reset acts immediately, without a clock edge.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_inst  <= 9'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef FETCH_CNT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
`ifdef FETCH_CNT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // Next-state and datapath decisions; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
`ifdef FETCH_CNT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
`ifdef FETCH_CNT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            S_RUN: begin
                // Priority: branch squashes, then stall freezes, then halt, then fetch.
                if (BranchTaken) begin
                    w_pc_nxt    = BranchTarget;
                    w_valid_nxt = 1'b0;
                end else if (Stall) begin
                    w_pc_nxt    = r_pc;
                end else if (Instruction == HALT_WORD) begin
                    // Halt word is consumed here and never handed to decode.
                    w_state_nxt = S_HALTED;
                    w_done_nxt  = 1'b1;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_inst_nxt  = Instruction;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + 10'd1;
`ifdef FETCH_CNT_EN
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
`endif
                end
            end
            S_HALTED: begin
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b1;
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_done_nxt  = 1'b0;
`ifdef FETCH_CNT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
//==============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch against a behavioural
//               program-execution model over a 1024-word instruction memory.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_inst_fetch;

    localparam logic [9:0] START_ADDR = 10'd0;
    localparam logic [8:0] HALT       = 9'h1FF;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic       Start;
    logic       Stall;
    logic       BranchTaken;
    logic [9:0] BranchTarget;
    logic [8:0] Instruction;
    logic [9:0] Address;
    logic [8:0] InstOut;
    logic       InstValid;
    logic       Done;
`ifdef FETCH_CNT_EN
    logic [15:0] InstCount;
`endif

    logic [8:0] mem [0:1023];

    assign Instruction = mem[Address];

    inst_fetch #(
        .START_ADDR (START_ADDR),
        .HALT_WORD  (HALT)
    ) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .Start        (Start),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instruction  (Instruction),
        .Address      (Address),
        .InstOut      (InstOut),
        .InstValid    (InstValid),
        .Done         (Done)
`ifdef FETCH_CNT_EN
        ,
        .InstCount    (InstCount)
`endif
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_mode;
    logic [9:0]  m_pc;
    logic [8:0]  m_inst;
    logic        m_valid;
    logic        m_done;
    logic [15:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = START_ADDR;
        m_inst  = 9'd0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_cnt   = 16'd0;
    endtask

    // One clock edge of program execution as seen by decode.
    task automatic model_step();
        if (m_mode == 1) begin
            if (BranchTaken) begin
                m_pc    = BranchTarget;
                m_valid = 1'b0;
            end else if (!Stall) begin
                if (mem[m_pc] == HALT) begin
                    m_mode  = 2;
                    m_done  = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_inst  = mem[m_pc];
                    m_valid = 1'b1;
                    m_pc    = 10'((int'(m_pc) + 1) % 1024);
                    m_cnt   = m_cnt + 16'd1;
                end
            end
        end else if (Start) begin
            m_mode = 1;
            m_pc   = START_ADDR;
            m_done = 1'b0;
            m_cnt  = 16'd0;
        end
    endtask

    task automatic check_all(input string where);
        check_eq({where, ".addr"},  32'(Address),   32'(m_pc));
        check_eq({where, ".inst"},  32'(InstOut),   32'(m_inst));
        check_eq({where, ".valid"}, 32'(InstValid), 32'(m_valid));
        check_eq({where, ".done"},  32'(Done),      32'(m_done));
`ifdef FETCH_CNT_EN
        check_eq({where, ".cnt"},   32'(InstCount), 32'(m_cnt));
`endif
    endtask

    task automatic tick(input string where);
        @(posedge Clk);
        model_step();
        #1;
        check_all(where);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 510));
        ResetN = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 10'd0;
        model_reset();
        #12;
        check_all("reset");
        ResetN = 1'b1;
        tick("idle");

        // Short program ending in the halt word
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = HALT;
        Start = 1'b1;
        tick("start");
        Start = 1'b0;
        begin
            int n;
            n = 0;
            while (!Done && n < 20) begin
                tick("prog");
                n++;
            end
            check_eq("prog_done_in_time", 32'(Done), 32'd1);
        end
        check_eq("halt_addr", 32'(Address), 32'd3);
        check_eq("halt_last_inst", 32'(InstOut), 32'h003);
`ifdef FETCH_CNT_EN
        check_eq("halt_count", 32'(InstCount), 32'd3);
`endif
        tick("halted_hold");

        // Restart from halted
        Start = 1'b1;
        tick("restart");
        Start = 1'b0;
        check_eq("restart_done_low", 32'(Done), 32'd0);
        check_eq("restart_pc", 32'(Address), 32'(START_ADDR));

        // Stall held at PC=5
        BranchTaken = 1'b1; BranchTarget = 10'd5;
        tick("br5");
        BranchTaken = 1'b0; Stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall5");
        check_eq("stall_addr", 32'(Address), 32'd5);
        Stall = 1'b0;
        tick("unstall");
        check_eq("unstall_inst", 32'(InstOut), 32'(mem[5]));

        // Branch to PC=7, then branch+stall together redirect to 200
        BranchTaken = 1'b1; BranchTarget = 10'd7;
        tick("br7");
        BranchTarget = 10'd200; Stall = 1'b1;
        tick("br200_stall");
        check_eq("br200_addr", 32'(Address), 32'd200);
        check_eq("br200_squash", 32'(InstValid), 32'd0);
        BranchTaken = 1'b0; Stall = 1'b0;
        tick("after_br200");
        check_eq("mem200", 32'(InstOut), 32'(mem[200]));

        // Branch to current PC: refetch after a bubble
        BranchTaken = 1'b1; BranchTarget = Address;
        tick("self_br");
        BranchTaken = 1'b0;
        tick("self_refetch");

        // PC wrap at the top of memory
        BranchTaken = 1'b1; BranchTarget = 10'd1023;
        tick("br1023");
        BranchTaken = 1'b0;
        tick("wrap");
        check_eq("wrap_addr", 32'(Address), 32'd0);
        check_eq("wrap_valid", 32'(InstValid), 32'd1);

        // Randomized traffic with sparse halt words
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 99) < 3) ? HALT : 9'($urandom_range(0, 510));
        for (int c = 0; c < 600; c++) begin
            Stall        = ($urandom_range(0, 3) == 0);
            BranchTaken  = ($urandom_range(0, 7) == 0);
            BranchTarget = 10'($urandom_range(0, 1023));
            Start        = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        // Asynchronous reset mid-run at PC=42
        Stall = 1'b0; BranchTaken = 1'b0;
        mem[42] = 9'h02A; mem[43] = 9'h02B;
        Start = 1'b1;
        tick("pre42_start");
        Start = 1'b0; BranchTaken = 1'b1; BranchTarget = 10'd42;
        tick("br42");
        BranchTaken = 1'b0;
        check_eq("at42", 32'(Address), 32'd42);
        #2;
        ResetN = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        check_all("reset_held");
        tick("idle_after_reset");
        tick("idle_after_reset2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
